// File: rtl/mpc_pipe_ctrl_if.sv
// mpc_pipe_ctrl_if: the ID-stage instruction fields and EX-stage ALU flags that
// enter the main control unit, and the stage controls and hazard signals it
// returns to the datapath.
interface mpc_pipe_ctrl_if #(
  parameter int OP_WIDTH = 6,
  parameter int RA_WIDTH = 5
);
  // ID stage instruction
  logic                iValid;
  logic [OP_WIDTH-1:0] iOperation;
  logic [RA_WIDTH-1:0] iRs;
  logic [RA_WIDTH-1:0] iRt;
  logic [RA_WIDTH-1:0] iRd;
  // EX stage ALU flags
  logic                iBranchTaken;
  logic                iOverflow;
  // Hazard control
  logic                oStall;
  logic                oFlush;
  // EX stage controls
  logic                oExRegDst;
  logic                oExALUSrc;
  logic                oExBranch;
  logic                oExJump;
  // Last MEM stage controls
  logic                oMemRead;
  logic                oMemWrite;
  // WB stage controls
  logic                oWbRegWrite;
  logic                oWbMemtoReg;
  logic [RA_WIDTH-1:0] oWbDestReg;
  // Event pulses
  logic                oIllegal;
  logic                oTrap;

  // Datapath side: presents the ID instruction and EX flags, consumes controls.
  modport master (
    output iValid, iOperation, iRs, iRt, iRd, iBranchTaken, iOverflow,
    input  oStall, oFlush, oExRegDst, oExALUSrc, oExBranch, oExJump,
    input  oMemRead, oMemWrite, oWbRegWrite, oWbMemtoReg, oWbDestReg,
    input  oIllegal, oTrap
  );

  // Control-unit side.
  modport slave (
    input  iValid, iOperation, iRs, iRt, iRd, iBranchTaken, iOverflow,
    output oStall, oFlush, oExRegDst, oExALUSrc, oExBranch, oExJump,
    output oMemRead, oMemWrite, oWbRegWrite, oWbMemtoReg, oWbDestReg,
    output oIllegal, oTrap
  );
endinterface

// File: rtl/mpc_pipe_ctrl.sv
// mpc_pipe_ctrl: pipelined main control unit for the 5-stage MIPS core.
// Decodes the ID opcode into a control bundle and carries it through the
// ID/EX, EX/MEM[1..MEM_LAT] and MEM/WB registers. Raises a load-use stall and
// a jump / taken-branch flush; flush always wins over stall.
// Optional feature macro: MPC_CU_OVF_TRAP_EN -- an R-format that overflows in
// EX loses its register write, flushes the front end and pulses oTrap.
// Without the macro iOverflow is ignored and oTrap is tied low.
module mpc_pipe_ctrl #(
  parameter int OP_WIDTH = 6,
  parameter int RA_WIDTH = 5,
  parameter int MEM_LAT  = 1   // data-memory latency, 1..4 EX/MEM stages
) (
  input  logic           clk,
  input  logic           resetn,
  mpc_pipe_ctrl_if.slave bus
);

  localparam logic [OP_WIDTH-1:0] OP_RFMT = OP_WIDTH'(6'h00);
  localparam logic [OP_WIDTH-1:0] OP_J    = OP_WIDTH'(6'h02);
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(6'h04);
  localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(6'h23);
  localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6'h2B);

  // One instruction's worth of control. memRead marks a load and regDst marks
  // an R-format, so no separate opcode needs to travel down the pipe.
  typedef struct packed {
    logic                regDst;
    logic                aluSrc;
    logic                branch;
    logic                jump;
    logic                memRead;
    logic                memWrite;
    logic                regWrite;
    logic                memtoReg;
    logic [RA_WIDTH-1:0] dest;
  } ctrlBundle_t;

  localparam ctrlBundle_t BUBBLE = '0;

  ctrlBundle_t idCtrl;
  ctrlBundle_t exCtrl;
  ctrlBundle_t exOut;
  ctrlBundle_t memPipe [MEM_LAT];
  ctrlBundle_t wbCtrl;

  logic idUnknown;
  logic idUsesRt;
  logic loadHazard;
  logic ovfTrap;
  logic flush;
  logic stall;
  logic illegalQ;
  logic trapQ;
  logic unusedBits;

  // A load ahead of ID blocks the ID instruction when it writes a nonzero
  // register that ID reads (rs always, rt only for formats that read rt).
  function automatic logic loadUseOn(input ctrlBundle_t         c,
                                     input logic [RA_WIDTH-1:0] rs,
                                     input logic [RA_WIDTH-1:0] rt,
                                     input logic                useRt);
    return c.memRead && (c.dest != '0) &&
           ((c.dest == rs) || (useRt && (c.dest == rt)));
  endfunction

  // Decode the ID opcode; unknown opcodes and empty slots become bubbles.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path through
    // the case statement can infer a latch.
    idCtrl    = BUBBLE;
    idUnknown = 1'b0;
    if (bus.iValid) begin
      case (bus.iOperation)
        OP_LW: begin
          idCtrl.aluSrc   = 1'b1;
          idCtrl.memRead  = 1'b1;
          idCtrl.regWrite = 1'b1;
          idCtrl.memtoReg = 1'b1;
          idCtrl.dest     = bus.iRt;
        end
        OP_SW: begin
          idCtrl.aluSrc   = 1'b1;
          idCtrl.memWrite = 1'b1;
        end
        OP_RFMT: begin
          idCtrl.regDst   = 1'b1;
          idCtrl.regWrite = 1'b1;
          idCtrl.dest     = bus.iRd;
        end
        OP_BEQ:  idCtrl.branch = 1'b1;
        OP_J:    idCtrl.jump   = 1'b1;
        default: idUnknown     = 1'b1;
      endcase
      // r0 is hardwired to zero, so a write to it is dropped here once.
      if (idCtrl.dest == '0) begin
        idCtrl.regWrite = 1'b0;
      end
    end
  end

  // Look for a load in EX or in any MEM stage that has not yet delivered data.
  always_comb begin
    idUsesRt   = (bus.iOperation == OP_RFMT) || (bus.iOperation == OP_SW) ||
                 (bus.iOperation == OP_BEQ);
    loadHazard = loadUseOn(exCtrl, bus.iRs, bus.iRt, idUsesRt);
    for (int k = 0; k < MEM_LAT - 1; k++) begin
      loadHazard = loadHazard | loadUseOn(memPipe[k], bus.iRs, bus.iRt, idUsesRt);
    end
  end

`ifdef MPC_CU_OVF_TRAP_EN
  // An R-format that overflowed in EX must never reach the register file.
  assign ovfTrap    = exCtrl.regDst && bus.iOverflow;
  assign unusedBits = ^{wbCtrl.regDst, wbCtrl.aluSrc, wbCtrl.branch,
                        wbCtrl.jump, wbCtrl.memRead, wbCtrl.memWrite};
`else
  // Overflow is not architecturally visible in this build.
  assign ovfTrap    = 1'b0;
  assign unusedBits = ^{bus.iOverflow, wbCtrl.regDst, wbCtrl.aluSrc,
                        wbCtrl.branch, wbCtrl.jump, wbCtrl.memRead,
                        wbCtrl.memWrite};
`endif

  // Redirects resolved in EX kill the younger instruction; a flush makes the
  // stall irrelevant because the stalled instruction is discarded anyway.
  assign flush = exCtrl.jump || (exCtrl.branch && bus.iBranchTaken) || ovfTrap;
  assign stall = bus.iValid && loadHazard && !flush;

  // EX result bundle: drop the register write of a trapped R-format.
  always_comb begin
    exOut = exCtrl;
    if (ovfTrap) begin
      exOut.regWrite = 1'b0;
    end
  end

  // Pipeline registers ID/EX, EX/MEM chain, MEM/WB and the two event pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exCtrl <= BUBBLE;
      // NOTE: the EX/MEM chain is pipeline state, not storage; every stage is
      // reset so no stale control can fire after reset.
      for (int k = 0; k < MEM_LAT; k++) begin
        memPipe[k] <= BUBBLE;
      end
      wbCtrl   <= BUBBLE;
      illegalQ <= 1'b0;
      trapQ    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so each stage captures the value its
      // predecessor held before this edge, regardless of statement order.
      exCtrl     <= (stall || flush) ? BUBBLE : idCtrl;
      memPipe[0] <= exOut;
      for (int k = 1; k < MEM_LAT; k++) begin
        memPipe[k] <= memPipe[k-1];
      end
      wbCtrl   <= memPipe[MEM_LAT-1];
      // Only report an unknown opcode once it actually leaves ID.
      illegalQ <= idUnknown && !stall && !flush;
      trapQ    <= ovfTrap;
    end
  end

  assign bus.oStall      = stall;
  assign bus.oFlush      = flush;
  assign bus.oExRegDst   = exCtrl.regDst;
  assign bus.oExALUSrc   = exCtrl.aluSrc;
  assign bus.oExBranch   = exCtrl.branch;
  assign bus.oExJump     = exCtrl.jump;
  assign bus.oMemRead    = memPipe[MEM_LAT-1].memRead;
  assign bus.oMemWrite   = memPipe[MEM_LAT-1].memWrite;
  assign bus.oWbRegWrite = wbCtrl.regWrite;
  assign bus.oWbMemtoReg = wbCtrl.memtoReg;
  assign bus.oWbDestReg  = wbCtrl.dest;
  assign bus.oIllegal    = illegalQ;
  assign bus.oTrap       = trapQ;

endmodule

// File: tb/tb_mpc_pipe_ctrl.sv
// tb_mpc_pipe_ctrl: drives one instruction stream into two control units
// (MEM_LAT=1 and MEM_LAT=3) and compares every cycle against a model that
// keeps a per-cycle history of instructions entering EX and derives each
// stage's controls from the opcode rules.
`timescale 1ns/1ps
module tb_mpc_pipe_ctrl;

  localparam int NCYC = 2048;
  localparam logic [5:0] OP_RFMT = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
`ifdef MPC_CU_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic       stall;
    logic       flush;
    logic       exRegDst;
    logic       exAluSrc;
    logic       exBranch;
    logic       exJump;
    logic       memRead;
    logic       memWrite;
    logic       wbRegWrite;
    logic       wbMemtoReg;
    logic [4:0] wbDest;
    logic       illegal;
    logic       trap;
  } outs_t;

  // Instruction that entered EX in a given cycle; v=0 is an empty slot.
  typedef struct packed {
    logic       v;
    logic [5:0] op;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       kill;
  } instr_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       iValid;
  logic [5:0] iOperation;
  logic [4:0] iRs, iRt, iRd;
  logic       iBranchTaken, iOverflow;

  mpc_pipe_ctrl_if #(.OP_WIDTH(6), .RA_WIDTH(5)) bus1 ();
  mpc_pipe_ctrl_if #(.OP_WIDTH(6), .RA_WIDTH(5)) bus3 ();

  assign bus1.iValid = iValid;       assign bus3.iValid = iValid;
  assign bus1.iOperation = iOperation; assign bus3.iOperation = iOperation;
  assign bus1.iRs = iRs;             assign bus3.iRs = iRs;
  assign bus1.iRt = iRt;             assign bus3.iRt = iRt;
  assign bus1.iRd = iRd;             assign bus3.iRd = iRd;
  assign bus1.iBranchTaken = iBranchTaken; assign bus3.iBranchTaken = iBranchTaken;
  assign bus1.iOverflow = iOverflow; assign bus3.iOverflow = iOverflow;

  mpc_pipe_ctrl #(.OP_WIDTH(6), .RA_WIDTH(5), .MEM_LAT(1)) dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1));
  mpc_pipe_ctrl #(.OP_WIDTH(6), .RA_WIDTH(5), .MEM_LAT(3)) dut3 (
    .clk(clk), .resetn(resetn), .bus(bus3));

  outs_t obs [2];
  assign obs[0] = {bus1.oStall, bus1.oFlush, bus1.oExRegDst, bus1.oExALUSrc,
                   bus1.oExBranch, bus1.oExJump, bus1.oMemRead, bus1.oMemWrite,
                   bus1.oWbRegWrite, bus1.oWbMemtoReg, bus1.oWbDestReg,
                   bus1.oIllegal, bus1.oTrap};
  assign obs[1] = {bus3.oStall, bus3.oFlush, bus3.oExRegDst, bus3.oExALUSrc,
                   bus3.oExBranch, bus3.oExJump, bus3.oMemRead, bus3.oMemWrite,
                   bus3.oWbRegWrite, bus3.oWbMemtoReg, bus3.oWbDestReg,
                   bus3.oIllegal, bus3.oTrap};

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     cyc;
  int     floorIdx;
  instr_t hist [2][NCYC];
  bit     illNext [2];
  bit     trapNext [2];

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int latOf(input int lane);
    return (lane == 0) ? 1 : 3;
  endfunction

  function automatic string laneName(input int lane);
    return (lane == 0) ? "L1" : "L3";
  endfunction

  function automatic instr_t histAt(input int lane, input int idx);
    if (idx < 0 || idx < floorIdx) return '0;
    return hist[lane][idx];
  endfunction

  function automatic bit isOp(input instr_t r, input logic [5:0] op);
    return r.v && (r.op == op);
  endfunction

  function automatic bit knownOp(input logic [5:0] op);
    return op inside {OP_RFMT, OP_J, OP_BEQ, OP_LW, OP_SW};
  endfunction

  function automatic bit flushExp(input int lane);
    instr_t ex;
    ex = histAt(lane, cyc);
    return isOp(ex, OP_J) || (isOp(ex, OP_BEQ) && iBranchTaken) ||
           (TRAP_EN && isOp(ex, OP_RFMT) && iOverflow);
  endfunction

  // A load sitting k cycles past ID (k < latency) still blocks its consumer.
  function automatic bit loadUseExp(input int lane);
    bit     useRt;
    instr_t r;
    useRt = iOperation inside {OP_RFMT, OP_SW, OP_BEQ};
    for (int k = 0; k < latOf(lane); k++) begin
      r = histAt(lane, cyc - k);
      if (isOp(r, OP_LW) && r.rt != 5'd0 &&
          (r.rt == iRs || (useRt && r.rt == iRt))) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic outs_t expectedOuts(input int lane);
    outs_t      e;
    instr_t     ex, mem, wb;
    logic [4:0] wdest;
    ex  = histAt(lane, cyc);
    mem = histAt(lane, cyc - latOf(lane));
    wb  = histAt(lane, cyc - latOf(lane) - 1);
    e = '0;
    e.flush      = flushExp(lane);
    e.stall      = iValid && !e.flush && loadUseExp(lane);
    e.exRegDst   = isOp(ex, OP_RFMT);
    e.exAluSrc   = isOp(ex, OP_LW) || isOp(ex, OP_SW);
    e.exBranch   = isOp(ex, OP_BEQ);
    e.exJump     = isOp(ex, OP_J);
    e.memRead    = isOp(mem, OP_LW);
    e.memWrite   = isOp(mem, OP_SW);
    wdest        = isOp(wb, OP_LW) ? wb.rt : (isOp(wb, OP_RFMT) ? wb.rd : 5'd0);
    e.wbDest     = wdest;
    e.wbRegWrite = (isOp(wb, OP_LW) || isOp(wb, OP_RFMT)) && wdest != 5'd0 && !wb.kill;
    e.wbMemtoReg = isOp(wb, OP_LW);
    e.illegal    = illNext[lane];
    e.trap       = trapNext[lane];
    return e;
  endfunction

  // Compare both lanes against the model, then advance the model one cycle.
  task automatic sampleAndAdvance();
    outs_t  e;
    instr_t ex, nxt;
    bit     fl, st;
    if (!resetn) begin
      floorIdx = cyc + 1;
      for (int l = 0; l < 2; l++) begin
        illNext[l]  = 1'b0;
        trapNext[l] = 1'b0;
      end
    end
    for (int l = 0; l < 2; l++) begin
      e = expectedOuts(l);
      check($sformatf("%s_c%0d_hazard", laneName(l), cyc),
            {30'd0, obs[l].stall, obs[l].flush}, {30'd0, e.stall, e.flush});
      check($sformatf("%s_c%0d_stages", laneName(l), cyc),
            32'(obs[l][14:2]), 32'(e[14:2]));
      check($sformatf("%s_c%0d_pulses", laneName(l), cyc),
            {30'd0, obs[l].illegal, obs[l].trap}, {30'd0, e.illegal, e.trap});
    end
    for (int l = 0; l < 2; l++) begin
      nxt = '0;
      if (resetn) begin
        ex = histAt(l, cyc);
        fl = flushExp(l);
        st = iValid && !fl && loadUseExp(l);
        if (TRAP_EN && isOp(ex, OP_RFMT) && iOverflow) hist[l][cyc].kill = 1'b1;
        nxt.v       = iValid && knownOp(iOperation) && !st && !fl;
        nxt.op      = iOperation;
        nxt.rt      = iRt;
        nxt.rd      = iRd;
        illNext[l]  = iValid && !knownOp(iOperation) && !st && !fl;
        trapNext[l] = TRAP_EN && isOp(ex, OP_RFMT) && iOverflow;
      end else begin
        illNext[l]  = 1'b0;
        trapNext[l] = 1'b0;
      end
      hist[l][cyc+1] = nxt;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    sampleAndAdvance();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic bt, input logic ovf);
    iValid = v; iOperation = op; iRs = rs; iRt = rt; iRd = rd;
    iBranchTaken = bt; iOverflow = ovf;
  endtask

  task automatic randomInputs();
    int sel;
    sel = $urandom_range(0, 9);
    iValid = ($urandom_range(0, 9) != 0);
    case (sel)
      0, 1:    iOperation = OP_LW;
      2:       iOperation = OP_SW;
      3, 4, 5: iOperation = OP_RFMT;
      6:       iOperation = OP_BEQ;
      7:       iOperation = OP_J;
      8:       iOperation = 6'h3F;
      default: iOperation = 6'($urandom_range(0, 63));
    endcase
    iRs = 5'($urandom_range(0, 3));
    iRt = 5'($urandom_range(0, 3));
    iRd = 5'($urandom_range(0, 3));
    iBranchTaken = 1'($urandom_range(0, 1));
    iOverflow    = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stallCnt [2];
    cyc = 0;
    floorIdx = 0;
    for (int l = 0; l < 2; l++) begin
      illNext[l] = 1'b0;
      trapNext[l] = 1'b0;
      for (int i = 0; i < NCYC; i++) hist[l][i] = '0;
    end
    setIn(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    resetn = 1'b0;

    // Reset held with random inputs: every output low.
    for (int i = 0; i < 5; i++) begin
      randomInputs();
      #1;
      check("rst_zero_L1", 32'(obs[0]), 32'd0);
      check("rst_zero_L3", 32'(obs[1]), 32'd0);
      tick();
    end

    // Release: only bubbles flow for 3+MEM_LAT cycles.
    setIn(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("post_rst_wb_L1", 32'(obs[0].wbRegWrite), 32'd0);
      check("post_rst_wb_L3", 32'(obs[1].wbRegWrite), 32'd0);
      tick();
    end

    // LW r2 then ADD r3,r2,r4 held in ID: stall length equals MEM_LAT.
    setIn(1'b1, OP_LW, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    tick();
    setIn(1'b1, OP_RFMT, 5'd2, 5'd4, 5'd3, 1'b0, 1'b0);
    stallCnt[0] = 0;
    stallCnt[1] = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (obs[0].stall) stallCnt[0]++;
      if (obs[1].stall) stallCnt[1]++;
      if (i == 2) check("lw_wb_dest_L1", {26'd0, obs[0].wbRegWrite, obs[0].wbDest}, {26'd0, 1'b1, 5'd2});
      if (i == 4) check("lw_wb_dest_L3", {26'd0, obs[1].wbRegWrite, obs[1].wbDest}, {26'd0, 1'b1, 5'd2});
      tick();
    end
    check("lu_stall_cycles_L1", stallCnt[0], 1);
    check("lu_stall_cycles_L3", stallCnt[1], 3);

    // LW r2 then ADD r3,r5,r4: independent, no stall.
    setIn(1'b1, OP_LW, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    tick();
    setIn(1'b1, OP_RFMT, 5'd5, 5'd4, 5'd3, 1'b0, 1'b0);
    #1;
    check("indep_nostall_L1", 32'(obs[0].stall), 32'd0);
    check("indep_nostall_L3", 32'(obs[1].stall), 32'd0);
    tick();

    // Taken BEQ in EX while a load-use sits in ID: flush wins.
    setIn(1'b1, OP_LW, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    tick();
    setIn(1'b1, OP_BEQ, 5'd7, 5'd8, 5'd0, 1'b0, 1'b0);
    tick();
    setIn(1'b1, OP_RFMT, 5'd2, 5'd4, 5'd3, 1'b1, 1'b0);
    #1;
    check("beq_flush_L3", {30'd0, obs[1].flush, obs[1].stall}, {30'd0, 1'b1, 1'b0});
    check("beq_flush_L1", {30'd0, obs[0].flush, obs[0].stall}, {30'd0, 1'b1, 1'b0});
    tick();
    setIn(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("after_flush_ex_L1", {30'd0, obs[0].exBranch, obs[0].exRegDst}, 32'd0);
    check("after_flush_ex_L3", {30'd0, obs[1].exBranch, obs[1].exRegDst}, 32'd0);
    tick();

    // Unknown opcode: one-cycle oIllegal pulse.
    setIn(1'b1, 6'h3F, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    setIn(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("illegal_pulse_L1", 32'(obs[0].illegal), 32'd1);
    check("illegal_pulse_L3", 32'(obs[1].illegal), 32'd1);
    tick();
    #1;
    check("illegal_end_L1", 32'(obs[0].illegal), 32'd0);

    // ADDU to r0 never writes back.
    setIn(1'b1, OP_RFMT, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    tick();
    setIn(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    #1;
    check("r0_no_write_L1", 32'(obs[0].wbRegWrite), 32'd0);
    tick();

    // ADD r6 overflowing in EX.
    setIn(1'b1, OP_RFMT, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0);
    tick();
    setIn(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    #1;
    check("ovf_flush_L1", 32'(obs[0].flush), 32'(TRAP_EN));
    tick();
    setIn(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("ovf_trap_L1", 32'(obs[0].trap), 32'(TRAP_EN));
    tick();
    #1;
    check("ovf_wb_L1", {26'd0, obs[0].wbRegWrite, obs[0].wbDest}, {26'd0, !TRAP_EN, 5'd6});
    tick();

    // Random traffic with one mid-run reset.
    for (int i = 0; i < 1200; i++) begin
      randomInputs();
      if (i == 400) resetn = 1'b0;
      if (i == 402) resetn = 1'b1;
      if (i == 400) begin
        #1;
        check("midrun_rst_L1", 32'(obs[0][14:0]), 32'd0);
        check("midrun_rst_L3", 32'(obs[1][14:0]), 32'd0);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
